// File: rtl/audio_dac_feeder_if.sv
// Stream bundle for audio_dac_feeder: L/R pair input and the two DAC channels.
// The slave modport is the feeder's view; master is the producer/AUDIO side.
interface audio_dac_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] to_dac_left_channel_data;
  logic              to_dac_left_channel_valid;
  logic              to_dac_left_channel_ready;
  logic [DATA_W-1:0] to_dac_right_channel_data;
  logic              to_dac_right_channel_valid;
  logic              to_dac_right_channel_ready;

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready,
    output to_dac_left_channel_data,
    output to_dac_left_channel_valid,
    input  to_dac_left_channel_ready,
    output to_dac_right_channel_data,
    output to_dac_right_channel_valid,
    input  to_dac_right_channel_ready
  );

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready,
    input  to_dac_left_channel_data,
    input  to_dac_left_channel_valid,
    output to_dac_left_channel_ready,
    input  to_dac_right_channel_data,
    input  to_dac_right_channel_valid,
    output to_dac_right_channel_ready
  );
endinterface

// File: rtl/audio_dac_feeder.sv
// Elastic stereo FIFO feeding lockstep L/R DAC slots with underrun filler.
// Optional AUDIO_VOLUME_EN adds a Q1.7 volume gain applied at slot load.
module audio_dac_feeder #(
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 64,
  parameter int PRIME_LEVEL   = 32,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  audio_dac_feeder_if.slave           bus,
  input  logic                        mono,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 underrun_cnt
`ifdef AUDIO_VOLUME_EN
  ,
  input  logic [7:0]                  volume
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t state, state_d;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [LW-1:0]       level, level_d;
  logic                in_rdy;
  logic                wr, load, pop, underrun;
  logic                l_vld, r_vld;
  logic [DATA_W-1:0]   l_dat, r_dat;
  logic [DATA_W-1:0]   last_l, last_r;
  logic [DATA_W-1:0]   pop_l, pop_r;
  logic [DATA_W-1:0]   src_l, src_r;
  logic [DATA_W-1:0]   wr_r;

`ifdef AUDIO_VOLUME_EN
  localparam logic signed [DATA_W+8:0] SMAX =
    {10'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+8:0] SMIN =
    {10'h3FF, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] scale(
    input logic [DATA_W-1:0] s,
    input logic [7:0]        v
  );
    logic signed [DATA_W+8:0] p;
    p = (DATA_W+9)'($signed(s)) *
        (DATA_W+9)'($signed({1'b0, v}));
    p = p >>> 7;
    if (p > SMAX) return SMAX[DATA_W-1:0];
    if (p < SMIN) return SMIN[DATA_W-1:0];
    return p[DATA_W-1:0];
  endfunction
`endif

  assign bus.in_ready = in_rdy;
  assign bus.to_dac_left_channel_data   = l_dat;
  assign bus.to_dac_left_channel_valid  = l_vld;
  assign bus.to_dac_right_channel_data  = r_dat;
  assign bus.to_dac_right_channel_valid = r_vld;
  assign fifo_level = level;

  assign wr   = bus.in_valid & in_rdy;
  assign wr_r = mono ? bus.in_left : bus.in_right;

  // a pair is only loaded once both slots have drained
  assign load     = !l_vld && !r_vld;
  assign pop      = load && state == RUN && level != '0;
  assign underrun = load && state == RUN && level == '0;
  assign level_d  = level + LW'(wr) - LW'(pop);

  always_comb begin
    {pop_l, pop_r} = mem[rptr];
`ifdef AUDIO_VOLUME_EN
    pop_l = scale(pop_l, volume);
    pop_r = scale(pop_r, volume);
`endif
    src_l = '0;
    src_r = '0;
    unique case (1'b1)
      pop: begin
        src_l = pop_l;
        src_r = pop_r;
      end
      (UNDERRUN_HOLD != 0): begin
        src_l = last_l;
        src_r = last_r;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      PRIME: if (level >= LW'(PRIME_LEVEL)) state_d = RUN;
      RUN:   if (underrun) state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {bus.in_left, wr_r};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PRIME;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      in_rdy       <= 1'b0;
      l_vld        <= 1'b0;
      r_vld        <= 1'b0;
      l_dat        <= '0;
      r_dat        <= '0;
      last_l       <= '0;
      last_r       <= '0;
      underrun_cnt <= '0;
    end else begin
      state  <= state_d;
      level  <= level_d;
      in_rdy <= level_d != LW'(FIFO_DEPTH);
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        last_l <= pop_l;
        last_r <= pop_r;
      end
      if (load) begin
        l_vld <= 1'b1;
        r_vld <= 1'b1;
        l_dat <= src_l;
        r_dat <= src_r;
      end else begin
        if (bus.to_dac_left_channel_ready)  l_vld <= 1'b0;
        if (bus.to_dac_right_channel_ready) r_vld <= 1'b0;
      end
      if (underrun && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Randomized scoreboard bench for audio_dac_feeder with a queue-based model.
// Build with +define+AUDIO_VOLUME_EN to also exercise the volume path.
module tb_audio_dac_feeder;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int PRIME = 32;
  localparam int HOLD  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mono = 1'b0;
  logic [6:0]  fifo_level;
  logic [15:0] underrun_cnt;
`ifdef AUDIO_VOLUME_EN
  logic [7:0]  volume = 8'd128;
`endif

  audio_dac_feeder_if #(.DATA_W(DW)) bus();

  audio_dac_feeder #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH),
    .PRIME_LEVEL(PRIME), .UNDERRUN_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mono(mono),
    .fifo_level(fifo_level),
    .underrun_cnt(underrun_cnt)
`ifdef AUDIO_VOLUME_EN
    ,
    .volume(volume)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit rnd_data = 1'b1;

  logic [31:0] mq[$];
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];
  bit          m_run, m_lb, m_rb, m_inrdy;
  logic [31:0] m_last;
  int          m_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_scale(input logic [15:0] s);
`ifdef AUDIO_VOLUME_EN
    int p;
    p = int'($signed(s)) * int'(volume);
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
`else
    return s;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: begin
        bus.to_dac_left_channel_ready  = 1'b1;
        bus.to_dac_right_channel_ready = 1'b1;
      end
      1: begin
        bus.to_dac_left_channel_ready  = 1'b1;
        bus.to_dac_right_channel_ready = (cyc % 4) == 0;
      end
      2: begin
        bus.to_dac_left_channel_ready  = 1'b0;
        bus.to_dac_right_channel_ready = 1'b0;
      end
      default: begin
        bus.to_dac_left_channel_ready  = 1'($urandom);
        bus.to_dac_right_channel_ready = 1'($urandom);
      end
    endcase
  end

  // reference model: predicts state after the coming edge
  always @(negedge clk) begin : model
    logic [31:0] p, pair;
    int          lvl;
    bit          run0, acc;
    if (!reset) begin
      mq.delete();
      exp_l.delete();
      exp_r.delete();
      m_run = 0; m_lb = 0; m_rb = 0; m_inrdy = 0;
      m_last = '0; m_cnt = 0;
      check("rst_l_valid", int'(bus.to_dac_left_channel_valid), 0);
      check("rst_r_valid", int'(bus.to_dac_right_channel_valid), 0);
      check("rst_l_data", int'(bus.to_dac_left_channel_data), 0);
      check("rst_r_data", int'(bus.to_dac_right_channel_data), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_underrun", int'(underrun_cnt), 0);
    end else begin
      check("in_ready", int'(bus.in_ready), int'(m_inrdy));
      check("fifo_level", int'(fifo_level), mq.size());
      check("underrun_cnt", int'(underrun_cnt), m_cnt);
      check("l_valid", int'(bus.to_dac_left_channel_valid), int'(m_lb));
      check("r_valid", int'(bus.to_dac_right_channel_valid), int'(m_rb));
      lvl  = mq.size();
      run0 = m_run;
      acc  = bus.in_valid && m_inrdy;
      pair = {bus.in_left, mono ? bus.in_left : bus.in_right};
      if (!m_lb && !m_rb) begin
        if (m_run && lvl > 0) begin
          p = mq.pop_front();
          p = {m_scale(p[31:16]), m_scale(p[15:0])};
          m_last = p;
        end else begin
          p = (HOLD != 0) ? m_last : 32'h0;
          if (m_run) begin
            if (m_cnt < 65535) m_cnt++;
            m_run = 0;
          end
        end
        exp_l.push_back(p[31:16]);
        exp_r.push_back(p[15:0]);
        m_lb = 1;
        m_rb = 1;
      end else begin
        if (m_lb && bus.to_dac_left_channel_ready)  m_lb = 0;
        if (m_rb && bus.to_dac_right_channel_ready) m_rb = 0;
      end
      if (!run0 && lvl >= PRIME) m_run = 1;
      if (acc) begin
        mq.push_back(pair);
        acc_cnt++;
      end
      m_inrdy = mq.size() != DEPTH;
    end
  end

  // monitor: pops the scoreboard on every DAC handshake
  always @(negedge clk) begin
    if (reset) begin
      if (bus.to_dac_left_channel_valid && bus.to_dac_left_channel_ready) begin
        if (exp_l.size() == 0) check("l_unexpected", 1, 0);
        else check("l_data", int'(bus.to_dac_left_channel_data),
                   int'(exp_l.pop_front()));
      end
      if (bus.to_dac_right_channel_valid && bus.to_dac_right_channel_ready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else check("r_data", int'(bus.to_dac_right_channel_data),
                   int'(exp_r.pop_front()));
      end
    end
  end

  task automatic drive_data();
    if (rnd_data) begin
      bus.in_left  = 16'($urandom);
      bus.in_right = 16'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push_n(input int n);
    int tgt;
    int k;
    tgt = acc_cnt + n;
    k = 0;
    while (acc_cnt < tgt && k < 400) begin
      bus.in_valid = 1'b1;
      drive_data();
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    if (acc_cnt < tgt) check("push_timeout", acc_cnt, tgt);
  endtask

  initial begin
    bus.in_left  = '0;
    bus.in_right = '0;
    bus.in_valid = 1'b0;
    bus.to_dac_left_channel_ready  = 1'b1;
    bus.to_dac_right_channel_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;

    push_n(PRIME - 1);
    idle(30);
    push_n(1);
    idle(120);
    check("underrun_after_drain", int'(underrun_cnt), 1);

    rdy_mode = 1;
    push_n(40);
    idle(200);

    rdy_mode = 2;
    bus.in_valid = 1'b1;
    repeat (80) begin
      drive_data();
      tick();
    end
    bus.in_valid = 1'b0;
    check("full_level", int'(fifo_level), DEPTH);
    check("full_in_ready", int'(bus.in_ready), 0);
    rdy_mode = 0;
    idle(200);

    mono = 1'b1;
    rnd_data = 1'b0;
    bus.in_left  = 16'h1234;
    bus.in_right = 16'h5555;
    push_n(40);
    idle(150);
    mono = 1'b0;

`ifdef AUDIO_VOLUME_EN
    volume = 8'd255;
    bus.in_left  = 16'h7000;
    bus.in_right = 16'h7000;
    push_n(40);
    idle(150);
    volume = 8'd64;
    bus.in_left  = 16'hFC18;
    bus.in_right = 16'hFC18;
    push_n(40);
    idle(150);
    volume = 8'd128;
`endif
    rnd_data = 1'b1;

    rdy_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      drive_data();
      if ($urandom % 50 == 0) mono = ~mono;
`ifdef AUDIO_VOLUME_EN
      if ($urandom % 200 == 0) volume = 8'($urandom);
`endif
      tick();
    end
    mono = 1'b0;
    bus.in_valid = 1'b0;

    rdy_mode = 0;
    push_n(36);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_l_valid", int'(bus.to_dac_left_channel_valid), 0);
    check("async_r_valid", int'(bus.to_dac_right_channel_valid), 0);
    check("async_level", int'(fifo_level), 0);
    tick();
    reset = 1'b1;
    push_n(40);
    idle(120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
